muldiv_seq_ctrl: RTL and testbench

//  Sequences multi-cycle MULT/MULTU/DIV/DIVU ops issued from EXE; owns the HI/LO architectural regs that feed
//  R64_Hi/R64_Lo into EXE->MEM. Raises Stall_Pipe to freeze the IF/ID/EXE pipeline regs while a HI/LO consumer
//  or a second muldiv op meets a busy unit. Sits beside the ALU in EXE; the hazard unit ORs Stall_Pipe into its stalls.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/muldiv_iter_core.sv | 68 ++++++
 rtl/muldiv_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide sequencer: op types, FSM states and the divide-by-zero LO value.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_type_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int unsigned MAX_W = 64;

    // LO result for any divide by zero; sliced to the datapath width at the use site.
    localparam logic [MAX_W-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step per enabled cycle,
// operating on operand magnitudes.
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] a_mag_i,
    input  logic [DATA_W-1:0] b_mag_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_diff;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, {DATA_W{acc_lo_q[0]}} & opb_q};
        div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift[DATA_W-1:0] - opb_q;

        if (load_i) begin
            acc_hi_d = '0;
            acc_lo_d = a_mag_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Remainder shifts in the next dividend bit; quotient bit enters LO from the right.
                acc_hi_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
                acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
            end else begin
                acc_hi_d = mul_sum[DATA_W:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the datapath is reset too, so an aborted op never leaves stale partial results visible.
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            if (load_i) begin
                opb_q <= b_mag_i;
            end
        end
    end

    assign hi_o = acc_hi_q;
    assign lo_o = acc_lo_q;

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the pipeline stall.
// Define FAST_MUL_EN for a single-cycle '*' multiply; the divide path stays iterative.
module muldiv_seq_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Op_Start,
    input  logic [1:0]        Op_Type,
    input  logic [DATA_W-1:0] Op_A,
    input  logic [DATA_W-1:0] Op_B,
    input  logic              HiLo_Rd_Req,
    input  logic              Wr_Hi,
    input  logic              Wr_Lo,
    output logic              Busy,
    output logic              Stall_Pipe,
    output logic              HiLo_WE,
    output logic              Div_By_Zero,
    output logic [DATA_W-1:0] Hi_Out,
    output logic [DATA_W-1:0] Lo_Out
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_div_q, neg_q, neg_rem_q, dbz_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] res_hi_q, res_lo_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              hilo_we_q, dbz_pulse_q;

    op_type_e          op_type;
    logic              is_div_op, is_signed_op, a_neg, b_neg, accept;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W-1:0] core_hi, core_lo;
    logic [DATA_W-1:0] fix_hi_d, fix_lo_d;
    logic [2*DATA_W-1:0] prod_neg;

    assign op_type      = op_type_e'(Op_Type);
    assign is_div_op    = (op_type == OP_DIVU) || (op_type == OP_DIV);
    assign is_signed_op = (op_type == OP_MULT) || (op_type == OP_DIV);
    assign a_neg        = is_signed_op & Op_A[DATA_W-1];
    assign b_neg        = is_signed_op & Op_B[DATA_W-1];
    assign a_mag        = a_neg ? ('0 - Op_A) : Op_A;
    assign b_mag        = b_neg ? ('0 - Op_B) : Op_B;
    assign accept       = (state_q == S_IDLE) & Op_Start;

    muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .load_i   (accept),
        .step_i   ((state_q == S_MUL) || (state_q == S_DIV)),
        .is_div_i (state_q == S_DIV),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

`ifdef FAST_MUL_EN
    logic                signed_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;

    // Low 2*DATA_W bits of a product of sign/zero-extended operands are correct for both signednesses.
    assign ext_a     = {{DATA_W{signed_q & op_a_q[DATA_W-1]}}, op_a_q};
    assign ext_b     = {{DATA_W{signed_q & op_b_q[DATA_W-1]}}, op_b_q};
    assign fast_prod = ext_a * ext_b;
`endif

    assign prod_neg = '0 - {core_hi, core_lo};

    always_comb begin
        fix_hi_d = core_hi;
        fix_lo_d = core_lo;
        if (dbz_q) begin
            fix_hi_d = op_a_q;
            fix_lo_d = DIV_ZERO_LO[DATA_W-1:0];
        end else if (is_div_q) begin
            // Truncating division: quotient sign from the XOR, remainder follows the dividend.
            if (neg_q)     fix_lo_d = '0 - core_lo;
            if (neg_rem_q) fix_hi_d = '0 - core_hi;
        end else if (neg_q) begin
            {fix_hi_d, fix_lo_d} = prod_neg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            op_a_q      <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_we_q   <= 1'b0;
            dbz_pulse_q <= 1'b0;
`ifdef FAST_MUL_EN
            signed_q    <= 1'b0;
            op_b_q      <= '0;
`endif
        end else begin
            hilo_we_q   <= 1'b0;
            dbz_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Op_Start) begin
                        state_q   <= is_div_op ? S_DIV : S_MUL;
                        cnt_q     <= '0;
                        is_div_q  <= is_div_op;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dbz_q     <= is_div_op && (Op_B == '0);
                        op_a_q    <= Op_A;
`ifdef FAST_MUL_EN
                        signed_q  <= is_signed_op;
                        op_b_q    <= Op_B;
`endif
                    end else begin
                        if (Wr_Hi) hi_q <= Op_A;
                        if (Wr_Lo) lo_q <= Op_A;
                    end
                end
`ifdef FAST_MUL_EN
                S_MUL: begin
                    res_hi_q  <= fast_prod[2*DATA_W-1:DATA_W];
                    res_lo_q  <= fast_prod[DATA_W-1:0];
                    hilo_we_q <= 1'b1;
                    state_q   <= S_DONE;
                end
`else
                S_MUL: begin
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_DIV: begin
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    res_hi_q    <= fix_hi_d;
                    res_lo_q    <= fix_lo_d;
                    hilo_we_q   <= 1'b1;
                    dbz_pulse_q <= dbz_q;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    hi_q    <= res_hi_q;
                    lo_q    <= res_lo_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy        = (state_q != S_IDLE);
    assign Stall_Pipe  = Busy & (HiLo_Rd_Req | Op_Start | Wr_Hi | Wr_Lo);
    assign HiLo_WE     = hilo_we_q;
    assign Div_By_Zero = dbz_pulse_q;
    assign Hi_Out      = hi_q;
    assign Lo_Out      = lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl: directed ops push expected results, a monitor checks each HiLo_WE.
module tb_muldiv_seq_ctrl;
    import mips_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DIV_LAT = 34;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              dbz;
        int                cyc;
        string             name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_start;
    logic [1:0]        op_type;
    logic [DATA_W-1:0] op_a, op_b;
    logic              rd_req, wr_hi, wr_lo;
    logic              busy, stall, hilo_we, dbz;
    logic [DATA_W-1:0] hi_out, lo_out;

    // cyc is the index of the next rising edge, so inside cycle n it reads n.
    int   cyc = 1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t pend;
    logic pend_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .Op_Start    (op_start),
        .Op_Type     (op_type),
        .Op_A        (op_a),
        .Op_B        (op_b),
        .HiLo_Rd_Req (rd_req),
        .Wr_Hi       (wr_hi),
        .Wr_Lo       (wr_lo),
        .Busy        (busy),
        .Stall_Pipe  (stall),
        .HiLo_WE     (hilo_we),
        .Div_By_Zero (dbz),
        .Hi_Out      (hi_out),
        .Lo_Out      (lo_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on each result pulse, then checks HI/LO one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                check({pend.name, "_hi"}, 64'(hi_out), 64'(pend.hi));
                check({pend.name, "_lo"}, 64'(lo_out), 64'(pend.lo));
                pend_valid = 1'b0;
            end
            if (hilo_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_hilo_we: got a result pulse at cycle %0d, want none", cyc);
                end else begin
                    pend = exp_q.pop_front();
                    check({pend.name, "_we_cycle"}, 64'(cyc), 64'(pend.cyc));
                    check({pend.name, "_dbz"}, 64'(dbz), 64'(pend.dbz));
                    pend_valid = 1'b1;
                end
            end else if (dbz === 1'b1) begin
                n_checks++;
                n_errors++;
                $display("FAIL stray_div_by_zero: got 1 without HiLo_WE at cycle %0d, want 0", cyc);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end of test after 20000 cycles, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: got Busy=1 after %0d cycles, want 0", budget);
        end
    endtask

    // Called at a negedge in IDLE; the op is sampled at edge t = current cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input string nm, input bit expect_result, output int t);
        int lat;
        op_start = 1'b1;
        op_type  = op;
        op_a     = a;
        op_b     = b;
        t        = cyc;
        lat      = op[1] ? DIV_LAT : MUL_LAT;
        if (expect_result) exp_q.push_back('{hi: eh, lo: el, dbz: ed, cyc: t + lat, name: nm});
        @(negedge clk);
        op_start = 1'b0;
    endtask

    initial begin
        int t;
        int t2;
        int n;
        rst_n = 1'b0; op_start = 1'b0; op_type = 2'b00; op_a = '0; op_b = '0;
        rd_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({hilo_we, dbz, stall}), 64'd0);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);

        // Signed multiply with mixed signs, plus the Busy window.
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg", 1'b1, t);
        check("mult_busy_first", 64'(busy), 64'd1);
        wait_to(t + MUL_LAT);
        check("mult_busy_last", 64'(busy), 64'd1);
        @(negedge clk);
        check("mult_busy_after", 64'(busy), 64'd0);

        // Signed divide while an MFHI/MFLO waits from T+5.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg", 1'b1, t);
        wait_to(t + 4);
        check("div_stall_no_req", 64'(stall), 64'd0);
        @(posedge clk);
        #1 rd_req = 1'b1;
        @(negedge clk);
        repeat (DIV_LAT - 4) begin
            check("div_rd_stall", 64'(stall), 64'd1);
            @(negedge clk);
        end
        check("div_rd_release", 64'(stall), 64'd0);
        check("div_rd_hi_now", 64'(hi_out), 64'hFFFF_FFFF);
        check("div_rd_lo_now", 64'(lo_out), 64'hFFFF_FFFD);
        rd_req = 1'b0;

        issue(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, "divu_zero", 1'b1, t);
        wait_idle(100);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "div_ovf", 1'b1, t);
        wait_idle(100);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, "multu_max", 1'b1, t);
        wait_idle(100);

        // Back-to-back: second op held from T+1 until the unit returns to IDLE at T+35.
        op_start = 1'b1; op_type = OP_DIVU; op_a = 32'd100; op_b = 32'd7;
        t = cyc;
        exp_q.push_back('{hi: 32'd2, lo: 32'd14, dbz: 1'b0, cyc: t + DIV_LAT, name: "b2b_first"});
        @(posedge clk);
        #1 op_type = OP_MULT; op_a = 32'hFFFF_FFFE; op_b = 32'hFFFF_FFFD;
        t2 = t + DIV_LAT + 1;
        exp_q.push_back('{hi: 32'd0, lo: 32'd6, dbz: 1'b0, cyc: t2 + MUL_LAT, name: "b2b_second"});
        @(negedge clk);
        check("b2b_stall", 64'(stall), 64'd1);
        wait_idle(100);
        check("b2b_accept_cycle", 64'(cyc), 64'(t2));
        check("b2b_stall_idle", 64'(stall), 64'd0);
        @(posedge clk);
        #1 op_start = 1'b0;
        @(negedge clk);
        check("b2b_second_busy", 64'(busy), 64'd1);
        wait_idle(100);

        // Reset mid-divide: no result, HI/LO cleared.
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, "div_abort", 1'b0, t);
        wait_to(t + 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi_out), 64'd0);
        check("abort_lo", 64'(lo_out), 64'd0);
        repeat (45) @(negedge clk);

        // MTHI / MTLO in IDLE.
        wr_hi = 1'b1; op_a = 32'h0000_1234;
        #1 check("mthi_stall", 64'(stall), 64'd0);
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_hi", 64'(hi_out), 64'h1234);
        check("mthi_lo", 64'(lo_out), 64'd0);
        wr_hi = 1'b1; wr_lo = 1'b1; op_a = 32'h0000_ABCD;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthilo_hi", 64'(hi_out), 64'hABCD);
        check("mthilo_lo", 64'(lo_out), 64'hABCD);

        // Op_Start together with MTHI: op wins, MTHI dropped; MTHI while busy stalls and is ignored.
        wr_hi = 1'b1;
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, "multu_vs_mthi", 1'b1, t);
        check("mthi_dropped", 64'(hi_out), 64'hABCD);
        op_a = 32'h5555_5555;
        #1 check("mthi_busy_stall", 64'(stall), 64'd1);
        @(negedge clk);
        wr_hi = 1'b0;
        wait_idle(100);

        n = 0;
        while ((exp_q.size() != 0 || pend_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
